hd_controlador: RTL and testbench
=================================

Name: hd_controlador

Overview:
- Parametrised successor to the processor's per-context storage ("HD").
- Presents a context-partitioned word store behind a valid/ready request/response handshake, on a single clock.
- Models a programmable access latency, range-checks every request, and adds a per-context bulk-clear operation.
- Sits between the process/context manager and the CPU datapath; one request is outstanding at a time.

Parameters:
- LARGURA, 32, data word width in bits.
- CONTEXTOS, 4, number of independent contexts (partitions).
- PALAVRAS, 51, words per context.
- LATENCIA, 4, cycles from request acceptance to read/write access; must be >= 1.
- CW, $clog2(CONTEXTOS) (min 1), context index width (derived).
- AW, $clog2(PALAVRAS) (min 1), address width (derived).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valido  in  1  request present.
- req_pronto  out  1  block can accept a request.
- op  in  2  00 read, 01 write, 10 clear context, 11 illegal.
- contexto  in  CW  target context.
- endereco  in  AW  word address within the context.
- dado_escrita  in  LARGURA  write data.
- resp_valido  out  1  response present.
- resp_pronto  in  1  consumer accepts the response.
- dado_saida  out  LARGURA  read data; 0 for non-read or error responses.
- erro  out  1  response flags a rejected request; valid while resp_valido=1.
- ocupado  out  1  high in any state other than OCIOSO.

Behaviour:
- Reset (async assert, sync release): FSM=OCIOSO; req_pronto=1; resp_valido=0; dado_saida=0; erro=0; ocupado=0; latency and clear counters=0. Storage array is NOT reset.
- Storage: CONTEXTOS x PALAVRAS words of LARGURA bits, single port, accessed only by the FSM.
- Acceptance: on a rising edge where req_valido=1 and req_pronto=1, capture op, contexto, endereco and dado_escrita. Input changes after acceptance are ignored.
- req_pronto=1 only in OCIOSO.
- States:
  - OCIOSO -> ERRO_RESP on accept if op=11, contexto>=CONTEXTOS, or (op is read/write and endereco>=PALAVRAS). The address is not checked for clear.
  - OCIOSO -> ESPERA on accept of a valid read/write; counter loaded with LATENCIA-1.
  - OCIOSO -> LIMPANDO on accept of a valid clear; index loaded with 0.
  - ESPERA: on each edge, if counter=0, perform the access and go to RESPOSTA; else decrement the counter. The access occurs on edge T0+LATENCIA, where T0 is the acceptance edge.
    - Read: dado_saida <= mem[ctx][addr].
    - Write: mem[ctx][addr] <= data; dado_saida <= 0.
  - LIMPANDO: on each edge write 0 to mem[ctx][index] and increment index. After writing index PALAVRAS-1, go to RESPOSTA with dado_saida=0. Takes exactly PALAVRAS edges; other contexts are untouched.
  - ERRO_RESP: one edge after acceptance, enter RESPOSTA with erro=1 and dado_saida=0. No storage access.
  - RESPOSTA: resp_valido=1; dado_saida and erro held stable until an edge with resp_pronto=1. That edge returns to OCIOSO, clears resp_valido and erro, and keeps dado_saida.
- Back-to-back: a new request cannot be accepted on the same edge as response completion. req_pronto rises in the cycle after.
- Backpressure: resp_pronto held low keeps the FSM in RESPOSTA indefinitely; req_pronto stays 0.
- Reset mid-operation: FSM returns immediately to OCIOSO.
  - A write not yet at its access edge is discarded.
  - A partial clear leaves already-zeroed words at zero and later words unchanged.
  - A pending response is dropped.
- Widths: the counter is sized for LATENCIA-1; the clear index is AW bits. Address comparisons are unsigned at full AW/CW width, so non-power-of-two PALAVRAS/CONTEXTOS values are rejected correctly.

Test Plan:
- Write ctx=1, addr=7, data=32'hDEADBEEF, then read ctx=1, addr=7 with resp_pronto=1.
  -> Each resp_valido rises after edge T0+4; read gives dado_saida=32'hDEADBEEF, erro=0.
- Write 32'h11 to ctx=0 addr=3 and 32'h22 to ctx=2 addr=3, then read both.
  -> Returns 32'h11 and 32'h22 (contexts isolated).
- Read addr=51, then write addr=63, then op=11.
  -> Each gives resp_valido one edge after acceptance with erro=1 and dado_saida=0; storage unchanged (a later read of ctx0 addr 50 returns its prior value).
- Fill ctx=3 addr 0..50 with nonzero values; clear ctx=3; read ctx=3 addr 0, 25, 50 and ctx=2 addr 0.
  -> Clear response after exactly 51 edges; ctx=3 reads return 0; ctx=2 is unchanged.
- Issue a read with resp_pronto=0 for 10 cycles.
  -> resp_valido and dado_saida stable throughout, req_pronto=0, ocupado=1; after resp_pronto=1, req_pronto=1 one cycle later.
- Assert rst_n=0 two edges into a write of 32'hAAAA to ctx0 addr5 (prior value 32'h5), and separately during a clear at index 20.
  -> All outputs reset immediately; a later read of ctx0 addr5 returns 32'h5; clear indices 0..19 read 0 and 20..50 keep their old values.

Source files
------------

// File: rtl/hd_controlador.sv
// rtl/hd_controlador.sv - context-partitioned word store with latency, range checks and context clear
module hd_controlador #(
  parameter int LARGURA   = 32,
  parameter int CONTEXTOS = 4,
  parameter int PALAVRAS  = 51,
  parameter int LATENCIA  = 4,
  localparam int CW = (CONTEXTOS > 1) ? $clog2(CONTEXTOS) : 1,
  localparam int AW = (PALAVRAS > 1) ? $clog2(PALAVRAS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valido,
  output logic               req_pronto,
  input  logic [1:0]         op,
  input  logic [CW-1:0]      contexto,
  input  logic [AW-1:0]      endereco,
  input  logic [LARGURA-1:0] dado_escrita,
  output logic               resp_valido,
  input  logic               resp_pronto,
  output logic [LARGURA-1:0] dado_saida,
  output logic               erro,
  output logic               ocupado
);

  localparam int CNTW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
  localparam int MW   = (CONTEXTOS * PALAVRAS > 1) ? $clog2(CONTEXTOS * PALAVRAS) : 1;
  localparam logic [CNTW-1:0] CNT_INI  = CNTW'(LATENCIA - 1);
  localparam logic [AW-1:0]   IDX_FIM  = AW'(PALAVRAS - 1);
  localparam logic [CW:0]     CTX_LIM  = (CW + 1)'(CONTEXTOS);
  localparam logic [AW:0]     ADDR_LIM = (AW + 1)'(PALAVRAS);

  localparam logic [1:0] OP_LER    = 2'b00;
  localparam logic [1:0] OP_ESC    = 2'b01;
  localparam logic [1:0] OP_LIMPAR = 2'b10;
  localparam logic [1:0] OP_ILEGAL = 2'b11;

  typedef enum logic [2:0] {OCIOSO, ESPERA, LIMPANDO, ERRO_RESP, RESPOSTA} estado_t;

  estado_t              estado_q;
  logic [1:0]           op_q;
  logic [CW-1:0]        ctx_q;
  logic [AW-1:0]        addr_q;
  logic [LARGURA-1:0]   dado_q;
  logic [CNTW-1:0]      cnt_q;
  logic [AW-1:0]        idx_q;
  logic                 req_pronto_q;
  logic                 resp_valido_q;
  logic                 erro_q;
  logic                 ocupado_q;
  logic [LARGURA-1:0]   dado_saida_q;

  logic [LARGURA-1:0]   mem [CONTEXTOS*PALAVRAS];

  logic                 aceita_d;
  logic                 invalido_d;
  logic [AW-1:0]        mem_addr_d;
  logic [MW-1:0]        mem_idx_d;
  logic                 mem_we_d;
  logic [LARGURA-1:0]   mem_wdata_d;

  // Request acceptance, range checking and flat storage index for the FSM's current access
  always_comb begin
    aceita_d    = req_valido && req_pronto_q;
    invalido_d  = (op == OP_ILEGAL) || ({1'b0, contexto} >= CTX_LIM) ||
                  (!op[1] && ({1'b0, endereco} >= ADDR_LIM));
    mem_addr_d  = (estado_q == LIMPANDO) ? idx_q : addr_q;
    mem_idx_d   = MW'(ctx_q) * MW'(PALAVRAS) + MW'(mem_addr_d);
    mem_we_d    = (estado_q == LIMPANDO) ||
                  ((estado_q == ESPERA) && (cnt_q == '0) && (op_q == OP_ESC));
    mem_wdata_d = (estado_q == LIMPANDO) ? '0 : dado_q;
  end

  // Storage array: single write port driven only by the FSM, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_d) mem[mem_idx_d] <= mem_wdata_d;
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q      <= OCIOSO;
      op_q          <= '0;
      ctx_q         <= '0;
      addr_q        <= '0;
      dado_q        <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      req_pronto_q  <= 1'b1;
      resp_valido_q <= 1'b0;
      erro_q        <= 1'b0;
      ocupado_q     <= 1'b0;
      dado_saida_q  <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (aceita_d) begin
            op_q         <= op;
            ctx_q        <= contexto;
            addr_q       <= endereco;
            dado_q       <= dado_escrita;
            req_pronto_q <= 1'b0;
            ocupado_q    <= 1'b1;
            if (invalido_d) begin
              estado_q <= ERRO_RESP;
            end else if (op == OP_LIMPAR) begin
              idx_q    <= '0;
              estado_q <= LIMPANDO;
            end else begin
              cnt_q    <= CNT_INI;
              estado_q <= ESPERA;
            end
          end
        end
        ESPERA: begin
          if (cnt_q == '0) begin
            dado_saida_q  <= (op_q == OP_LER) ? mem[mem_idx_d] : '0;
            erro_q        <= 1'b0;
            resp_valido_q <= 1'b1;
            estado_q      <= RESPOSTA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        LIMPANDO: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == IDX_FIM) begin
            dado_saida_q  <= '0;
            erro_q        <= 1'b0;
            resp_valido_q <= 1'b1;
            estado_q      <= RESPOSTA;
          end
        end
        ERRO_RESP: begin
          dado_saida_q  <= '0;
          erro_q        <= 1'b1;
          resp_valido_q <= 1'b1;
          estado_q      <= RESPOSTA;
        end
        RESPOSTA: begin
          if (resp_pronto) begin
            resp_valido_q <= 1'b0;
            erro_q        <= 1'b0;
            req_pronto_q  <= 1'b1;
            ocupado_q     <= 1'b0;
            estado_q      <= OCIOSO;
          end
        end
        default: begin
          resp_valido_q <= 1'b0;
          erro_q        <= 1'b0;
          req_pronto_q  <= 1'b1;
          ocupado_q     <= 1'b0;
          estado_q      <= OCIOSO;
        end
      endcase
    end
  end

  assign req_pronto  = req_pronto_q;
  assign resp_valido = resp_valido_q;
  assign dado_saida  = dado_saida_q;
  assign erro        = erro_q;
  assign ocupado     = ocupado_q;

endmodule

// File: tb/tb_hd_controlador.sv
// tb/tb_hd_controlador.sv - vector table, corner sequences and random checks for hd_controlador
module tb_hd_controlador;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valido = 1'b0;
  logic        req_pronto;
  logic [1:0]  op = 2'b00;
  logic [1:0]  contexto = 2'b00;
  logic [5:0]  endereco = 6'd0;
  logic [31:0] dado_escrita = 32'd0;
  logic        resp_valido;
  logic        resp_pronto = 1'b0;
  logic [31:0] dado_saida;
  logic        erro;
  logic        ocupado;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] modelo    [4][51];
  bit          conhecido [4][51];

  typedef struct {
    logic [1:0]  o;
    logic [1:0]  c;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
    int          el;
  } vetor_t;

  vetor_t tab[$];

  hd_controlador dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valido   (req_valido),
    .req_pronto   (req_pronto),
    .op           (op),
    .contexto     (contexto),
    .endereco     (endereco),
    .dado_escrita (dado_escrita),
    .resp_valido  (resp_valido),
    .resp_pronto  (resp_pronto),
    .dado_saida   (dado_saida),
    .erro         (erro),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input logic [31:0] real_v, input logic [31:0] esp);
    n_vec++;
    if (real_v !== esp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nome, real_v, esp);
    end
  endtask

  task automatic chk_reset_state(input string nome);
    chk({nome, " req_pronto"}, 32'(req_pronto), 32'd1);
    chk({nome, " resp_valido"}, 32'(resp_valido), 32'd0);
    chk({nome, " dado_saida"}, dado_saida, 32'd0);
    chk({nome, " erro"}, 32'(erro), 32'd0);
    chk({nome, " ocupado"}, 32'(ocupado), 32'd0);
  endtask

  // Present a request and return #1 after its acceptance edge
  task automatic issue(input logic [1:0] o, input logic [1:0] c, input logic [5:0] a,
                       input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    while (!req_pronto && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_pronto) chk("req_pronto timeout", 32'(req_pronto), 32'd1);
    op = o; contexto = c; endereco = a; dado_escrita = d; req_valido = 1'b1;
    @(posedge clk);
    #1;
    req_valido = 1'b0;
    op = 2'($urandom); contexto = 2'($urandom); endereco = 6'($urandom); dado_escrita = $urandom;
  endtask

  // Wait for the response, check it, hold backpressure for 'hold' cycles, then consume it
  task automatic finish(input string nome, input logic [31:0] ed, input bit cd,
                        input logic ee, input int el, input int hold);
    int lat = 0;
    logic [31:0] v0;
    while (!resp_valido && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nome, " latencia"}, 32'(lat), 32'(el));
    chk({nome, " erro"}, 32'(erro), 32'(ee));
    if (cd) chk({nome, " dado"}, dado_saida, ed);
    v0 = dado_saida;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nome, " hold resp_valido"}, 32'(resp_valido), 32'd1);
      chk({nome, " hold dado"}, dado_saida, v0);
      chk({nome, " hold req_pronto"}, 32'(req_pronto), 32'd0);
      chk({nome, " hold ocupado"}, 32'(ocupado), 32'd1);
    end
    resp_pronto = 1'b1;
    @(posedge clk);
    #1;
    resp_pronto = 1'b0;
    chk({nome, " resp_valido apos"}, 32'(resp_valido), 32'd0);
    chk({nome, " req_pronto apos"}, 32'(req_pronto), 32'd1);
  endtask

  task automatic atualiza(input logic [1:0] o, input logic [1:0] c, input logic [5:0] a,
                          input logic [31:0] d);
    if (o == 2'd1 && a < 6'd51) begin
      modelo[c][a] = d;
      conhecido[c][a] = 1'b1;
    end else if (o == 2'd2) begin
      for (int i = 0; i < 51; i++) begin
        modelo[c][i] = 32'd0;
        conhecido[c][i] = 1'b1;
      end
    end
  endtask

  // Reference behaviour: range rules, fixed latencies and a word array per context
  task automatic req_model(input string nome, input logic [1:0] o, input logic [1:0] c,
                           input logic [5:0] a, input logic [31:0] d, input int hold);
    logic        e;
    int          l;
    logic [31:0] ed;
    bit          cd;
    e  = (o == 2'd3) || (o != 2'd2 && a >= 6'd51);
    l  = e ? 1 : (o == 2'd2 ? 51 : 4);
    ed = 32'd0;
    cd = 1'b1;
    if (!e && o == 2'd0) begin
      ed = modelo[c][a];
      cd = conhecido[c][a];
    end
    issue(o, c, a, d);
    finish(nome, ed, cd, e, l, hold);
    if (!e) atualiza(o, c, a, d);
  endtask

  task automatic aplica_reset(input string nome);
    rst_n = 1'b0;
    #1;
    chk_reset_state(nome);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 51; a++) begin
        modelo[c][a] = 32'd0;
        conhecido[c][a] = 1'b0;
      end

    tab.push_back('{2'd1, 2'd1, 6'd7,  32'hDEADBEEF, 32'd0,        1'b0, 4});
    tab.push_back('{2'd0, 2'd1, 6'd7,  32'd0,        32'hDEADBEEF, 1'b0, 4});
    tab.push_back('{2'd1, 2'd0, 6'd3,  32'h11,       32'd0,        1'b0, 4});
    tab.push_back('{2'd1, 2'd2, 6'd3,  32'h22,       32'd0,        1'b0, 4});
    tab.push_back('{2'd0, 2'd0, 6'd3,  32'd0,        32'h11,       1'b0, 4});
    tab.push_back('{2'd0, 2'd2, 6'd3,  32'd0,        32'h22,       1'b0, 4});
    tab.push_back('{2'd1, 2'd0, 6'd50, 32'h5050,     32'd0,        1'b0, 4});
    tab.push_back('{2'd1, 2'd0, 6'd5,  32'h5,        32'd0,        1'b0, 4});
    tab.push_back('{2'd1, 2'd2, 6'd0,  32'h77,       32'd0,        1'b0, 4});
    tab.push_back('{2'd0, 2'd0, 6'd51, 32'd0,        32'd0,        1'b1, 1});
    tab.push_back('{2'd1, 2'd0, 6'd63, 32'hAAAA,     32'd0,        1'b1, 1});
    tab.push_back('{2'd3, 2'd0, 6'd0,  32'h1234,     32'd0,        1'b1, 1});
    tab.push_back('{2'd0, 2'd0, 6'd50, 32'd0,        32'h5050,     1'b0, 4});
    tab.push_back('{2'd0, 2'd0, 6'd5,  32'd0,        32'h5,        1'b0, 4});

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      issue(tab[i].o, tab[i].c, tab[i].a, tab[i].d);
      finish($sformatf("tab%0d", i), tab[i].ed, 1'b1, tab[i].ee, tab[i].el, 0);
      if (!tab[i].ee) atualiza(tab[i].o, tab[i].c, tab[i].a, tab[i].d);
    end

    issue(2'd0, 2'd1, 6'd7, 32'd0);
    finish("backpressure", 32'hDEADBEEF, 1'b1, 1'b0, 4, 10);

    for (int i = 0; i < 51; i++) req_model("fill3", 2'd1, 2'd3, 6'(i), 32'h300 + 32'(i) + 1, 0);
    issue(2'd2, 2'd3, 6'd0, 32'd0);
    finish("clear3", 32'd0, 1'b1, 1'b0, 51, 0);
    atualiza(2'd2, 2'd3, 6'd0, 32'd0);
    issue(2'd0, 2'd3, 6'd0, 32'd0);  finish("clr rd0",  32'd0,  1'b1, 1'b0, 4, 0);
    issue(2'd0, 2'd3, 6'd25, 32'd0); finish("clr rd25", 32'd0,  1'b1, 1'b0, 4, 0);
    issue(2'd0, 2'd3, 6'd50, 32'd0); finish("clr rd50", 32'd0,  1'b1, 1'b0, 4, 0);
    issue(2'd0, 2'd2, 6'd0, 32'd0);  finish("ctx2 rd0", 32'h77, 1'b1, 1'b0, 4, 0);

    issue(2'd1, 2'd0, 6'd5, 32'hAAAA);
    repeat (2) @(posedge clk);
    #1;
    aplica_reset("rst write");
    issue(2'd0, 2'd0, 6'd5, 32'd0);
    finish("rst write rd", 32'h5, 1'b1, 1'b0, 4, 0);

    for (int i = 0; i < 51; i++) req_model("refill3", 2'd1, 2'd3, 6'(i), 32'h300 + 32'(i) + 1, 0);
    issue(2'd2, 2'd3, 6'd0, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    aplica_reset("rst clear");
    for (int i = 0; i < 20; i++) modelo[3][i] = 32'd0;
    for (int i = 0; i < 51; i++) req_model($sformatf("partial rd%0d", i), 2'd0, 2'd3, 6'(i), 32'd0, 0);

    for (int k = 0; k < 80; k++) begin
      int          r;
      logic [1:0]  o;
      r = $urandom_range(0, 9);
      o = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      req_model($sformatf("rnd%0d", k), o, 2'($urandom), 6'($urandom_range(0, 63)), $urandom,
                $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
